// File: rtl/des_pkg.sv
// Shared definitions for the 3DES AHB master: register map, AHB encodings, FSM states.
package des_pkg;

    // Register offsets inside the 3DES slave
    localparam logic [7:0] OFF_KEY1   = 8'h00;
    localparam logic [7:0] OFF_KEY2   = 8'h08;
    localparam logic [7:0] OFF_KEY3   = 8'h10;
    localparam logic [7:0] OFF_DIN    = 8'h18;
    localparam logic [7:0] OFF_CTRL   = 8'h20;
    localparam logic [7:0] OFF_STATUS = 8'h28;
    localparam logic [7:0] OFF_DOUT   = 8'h30;

    // AHB encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HSIZE_DWORD   = 3'b011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic [3:0] HPROT_DATA    = 4'b0011;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WR_K1,
        ST_WR_K2,
        ST_WR_K3,
        ST_WR_DIN,
        ST_WR_CTRL,
        ST_RD_STAT,
        ST_RD_DOUT,
        ST_RESP
    } state_e;

    typedef enum logic [1:0] {
        P_IDLE,
        P_ADDR,
        P_DATA
    } xfer_phase_e;

    // Register targeted by the transfer issued in a given state
    function automatic logic [7:0] reg_offset(input state_e st);
        case (st)
            ST_WR_K1:   return OFF_KEY1;
            ST_WR_K2:   return OFF_KEY2;
            ST_WR_K3:   return OFF_KEY3;
            ST_WR_DIN:  return OFF_DIN;
            ST_WR_CTRL: return OFF_CTRL;
            ST_RD_STAT: return OFF_STATUS;
            ST_RD_DOUT: return OFF_DOUT;
            default:    return 8'h00;
        endcase
    endfunction

    function automatic logic is_write(input state_e st);
        return (st == ST_WR_K1) || (st == ST_WR_K2) || (st == ST_WR_K3) ||
               (st == ST_WR_DIN) || (st == ST_WR_CTRL);
    endfunction

    // Successor in the fixed write/read sequence (status polling handled by caller)
    function automatic state_e next_state(input state_e st);
        case (st)
            ST_WR_K1:   return ST_WR_K2;
            ST_WR_K2:   return ST_WR_K3;
            ST_WR_K3:   return ST_WR_DIN;
            ST_WR_DIN:  return ST_WR_CTRL;
            ST_WR_CTRL: return ST_RD_STAT;
            ST_RD_STAT: return ST_RD_DOUT;
            ST_RD_DOUT: return ST_RESP;
            default:    return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ahb_single_xfer.sv
// One non-overlapped AHB single transfer: address phase, data phase with wait
// states, error capture. start_i is taken on the edge it is sampled so that a new
// address phase can follow the previous data phase without a gap cycle.
module ahb_single_xfer
    import des_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [31:0] addr_i,
    input  logic        write_i,
    input  logic [63:0] wdata_i,   // sampled at the end of the address phase
    output logic        done_o,
    output logic        err_o,
    output logic [63:0] rdata_o,
    output logic [31:0] haddr_o,
    output logic        hwrite_o,
    output logic [1:0]  htrans_o,
    output logic [63:0] hwdata_o,
    input  logic        hready_i,
    input  logic        hresp_i,
    input  logic [63:0] hrdata_i
);

    xfer_phase_e phase_q;
    logic        err_q;
    logic [31:0] haddr_q;
    logic        hwrite_q;
    logic [1:0]  htrans_q;
    logic [63:0] hwdata_q;

    // Data phase ends on HREADY; an error seen anywhere in the data phase sticks
    assign done_o   = (phase_q == P_DATA) && hready_i;
    assign err_o    = err_q | hresp_i;
    assign rdata_o  = hrdata_i;
    assign haddr_o  = haddr_q;
    assign hwrite_o = hwrite_q;
    assign htrans_o = htrans_q;
    assign hwdata_o = hwdata_q;

    // Phase sequencer driving the registered AHB address/data signals
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            phase_q  <= P_IDLE;
            err_q    <= 1'b0;
            haddr_q  <= '0;
            hwrite_q <= 1'b0;
            htrans_q <= HTRANS_IDLE;
            hwdata_q <= '0;
        end else if (start_i && ((phase_q == P_IDLE) || done_o)) begin
            phase_q  <= P_ADDR;
            err_q    <= 1'b0;
            haddr_q  <= addr_i;
            hwrite_q <= write_i;
            htrans_q <= HTRANS_NONSEQ;
        end else begin
            case (phase_q)
                P_ADDR: begin
                    phase_q  <= P_DATA;
                    htrans_q <= HTRANS_IDLE;
                    hwdata_q <= wdata_i;
                end
                P_DATA: begin
                    if (hresp_i) err_q <= 1'b1;
                    if (hready_i) phase_q <= P_IDLE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/des_ahb_master.sv
// AHB master that programs a 3DES slave: writes keys, data and control, polls
// status, reads the result and returns it on a one-cycle response pulse.
module des_ahb_master
    import des_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] POLL_MAX  = 16'd1000
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_decrypt,
    input  logic [63:0] cmd_key1,
    input  logic [63:0] cmd_key2,
    input  logic [63:0] cmd_key3,
    input  logic [63:0] cmd_data,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_error,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [63:0] HWDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [63:0] HRDATA
);

    state_e      state_q, state_d;
    logic        launch, resp_err;
    logic [63:0] key1_q, key2_q, key3_q, data_q;
    logic        decrypt_q;
    logic [15:0] poll_q;
    logic        rsp_valid_q, rsp_error_q;
    logic [63:0] rsp_data_q;

    logic        xfer_done, xfer_err;
    logic [63:0] xfer_rdata;
    logic [31:0] xfer_addr;
    logic [63:0] xfer_wdata;

    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_error = rsp_error_q;
    assign rsp_data  = rsp_data_q;
    assign HSIZE     = HSIZE_DWORD;
    assign HBURST    = HBURST_SINGLE;
    assign HPROT     = HPROT_DATA;
    assign HMASTLOCK = 1'b0;

    // The next transfer's address comes from the state being entered
    assign xfer_addr = BASE_ADDR + {24'h0, reg_offset(state_d)};

    // Write data is needed one cycle after launch, when state_q already names the target
    always_comb begin
        case (state_q)
            ST_WR_K1:   xfer_wdata = key1_q;
            ST_WR_K2:   xfer_wdata = key2_q;
            ST_WR_K3:   xfer_wdata = key3_q;
            ST_WR_DIN:  xfer_wdata = data_q;
            ST_WR_CTRL: xfer_wdata = {62'h0, decrypt_q, 1'b1};
            default:    xfer_wdata = '0;
        endcase
    end

    // Next-state and transfer launch decision
    always_comb begin
        state_d  = state_q;
        launch   = 1'b0;
        resp_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_d = ST_WR_K1;
                    launch  = 1'b1;
                end
            end
            ST_WR_K1, ST_WR_K2, ST_WR_K3, ST_WR_DIN, ST_WR_CTRL, ST_RD_DOUT: begin
                if (xfer_done) begin
                    if (xfer_err || (state_q == ST_RD_DOUT)) begin
                        state_d  = ST_RESP;
                        resp_err = xfer_err;
                    end else begin
                        state_d = next_state(state_q);
                        launch  = 1'b1;
                    end
                end
            end
            ST_RD_STAT: begin
                if (xfer_done) begin
                    if (xfer_err) begin
                        state_d  = ST_RESP;
                        resp_err = 1'b1;
                    end else if (xfer_rdata[0]) begin
                        state_d = ST_RD_DOUT;
                        launch  = 1'b1;
                    end else if ((poll_q + 16'd1) >= POLL_MAX) begin
                        state_d  = ST_RESP;
                        resp_err = 1'b1;
                    end else begin
                        launch = 1'b1;
                    end
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, command capture, poll counter and registered response
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            poll_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_error_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= (state_d == ST_RESP);
            if ((state_q == ST_IDLE) && cmd_valid) begin
                key1_q    <= cmd_key1;
                key2_q    <= cmd_key2;
                key3_q    <= cmd_key3;
                data_q    <= cmd_data;
                decrypt_q <= cmd_decrypt;
                poll_q    <= '0;
            end
            if ((state_q == ST_RD_STAT) && xfer_done && !xfer_err && !xfer_rdata[0])
                poll_q <= poll_q + 16'd1;
            if ((state_d == ST_RESP) && (state_q != ST_RESP))
                rsp_error_q <= resp_err;
            if ((state_q == ST_RD_DOUT) && xfer_done && !xfer_err)
                rsp_data_q <= xfer_rdata;
        end
    end

    ahb_single_xfer u_xfer (
        .clk_i    (HCLK),
        .rst_i    (HRESET),
        .start_i  (launch),
        .addr_i   (xfer_addr),
        .write_i  (is_write(state_d)),
        .wdata_i  (xfer_wdata),
        .done_o   (xfer_done),
        .err_o    (xfer_err),
        .rdata_o  (xfer_rdata),
        .haddr_o  (HADDR),
        .hwrite_o (HWRITE),
        .htrans_o (HTRANS),
        .hwdata_o (HWDATA),
        .hready_i (HREADY),
        .hresp_i  (HRESP),
        .hrdata_i (HRDATA)
    );

endmodule

// File: doc/des_ahb_master.md
DES_AHB_MASTER -- requirements
Module: des_ahb_master

Interface
REQ-001 Parameter BASE_ADDR, default 32'h0000_0000, base address of the 3DES AHB slave.
REQ-002 Parameter POLL_MAX, default 16'd1000, maximum status reads before timeout.
REQ-003 HCLK  input  1  sole clock; all state updates on rising edge.
REQ-004 HRESET  input  1  synchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  high only in IDLE.
REQ-007 cmd_decrypt  input  1  0 = encrypt, 1 = decrypt.
REQ-008 cmd_key1, cmd_key2, cmd_key3  input  64 each  3DES keys.
REQ-009 cmd_data  input  64  plaintext or ciphertext block.
REQ-010 rsp_valid  output  1  one-cycle pulse, result available.
REQ-011 rsp_data  output  64  result block, held until next rsp_valid.
REQ-012 rsp_error  output  1  qualified by rsp_valid; slave error or timeout.
REQ-013 HADDR  output  32; HWRITE  output  1; HTRANS  output  2; HSIZE  output  3; HBURST  output  3; HPROT  output  4; HMASTLOCK  output  1; HWDATA  output  64.
REQ-014 HREADY  input  1; HRESP  input  1; HRDATA  input  64.

Function
REQ-015 Register map, offsets from BASE_ADDR: 0x00 KEY1, 0x08 KEY2, 0x10 KEY3, 0x18 DIN, 0x20 CTRL (bit0 start, bit1 decrypt), 0x28 STATUS (bit0 done), 0x30 DOUT.
REQ-016 Constant fields: HSIZE=3'b011, HBURST=3'b000 (SINGLE), HPROT=4'b0011, HMASTLOCK=0.
REQ-017 On cmd_valid && cmd_ready, all cmd_* fields are captured into internal registers; later input changes are ignored.
REQ-018 FSM states: IDLE, WR_K1, WR_K2, WR_K3, WR_DIN, WR_CTRL, RD_STAT, RD_DOUT, RESP.
REQ-019 Transfer sequence: IDLE -> WR_K1 -> WR_K2 -> WR_K3 -> WR_DIN -> WR_CTRL -> RD_STAT (repeat until done) -> RD_DOUT -> RESP -> IDLE.
REQ-020 Each transfer has a one-cycle address phase with HTRANS=NONSEQ (2'b10), followed by a data phase with HTRANS=IDLE (2'b00); transfers never overlap.
REQ-021 Address phase completes in one cycle; the data phase holds HWDATA stable and extends until HREADY=1.
REQ-022 The WR_CTRL data word is {62'b0, decrypt, 1'b1}.
REQ-023 RD_STAT: when the data phase ends with HRDATA[0]=1, go to RD_DOUT; otherwise increment the poll counter and issue a new read.
REQ-024 When the poll counter reaches POLL_MAX without done, go to RESP with rsp_error=1 and rsp_data unchanged.
REQ-025 HRESP=1 in any data phase aborts the sequence: go to RESP with rsp_error=1.
REQ-026 RD_DOUT captures HRDATA into rsp_data at data-phase completion.
REQ-027 RESP asserts rsp_valid for exactly one cycle, then returns to IDLE.
REQ-028 Best-case latency from command accept to rsp_valid is 15 cycles (7 transfers x 2 cycles + RESP), with zero wait states and done on the first poll.
REQ-029 HTRANS=IDLE whenever the FSM is in IDLE or RESP.

Reset
REQ-030 While HRESET=1 at a clock edge: state=IDLE, HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0, rsp_valid=0, rsp_error=0, rsp_data=0, poll counter=0.
REQ-031 Reset during any transfer abandons it immediately; no rsp_valid is produced for the aborted command.
REQ-032 cmd_ready=1 in the first cycle after reset deasserts.

Structure
REQ-033 Shared package des_pkg holds the register offset constants, the HTRANS/HSIZE/HBURST encodings and the FSM state enum.
REQ-034 One sub-module, ahb_single_xfer, performs one non-overlapped transfer (address phase, data phase, wait states, error) using a start/done handshake.

Verification
REQ-035 Encrypt with zero wait states, status done on first poll, DOUT=64'h1234_5678_9ABC_DEF0 -> rsp_valid at cycle 15, rsp_data=64'h1234_5678_9ABC_DEF0, rsp_error=0, with the HADDR sequence 0x00..0x30 as in REQ-015.
REQ-036 Two wait states on every data phase -> HWDATA is stable throughout each wait; rsp_valid arrives at cycle 29.
REQ-037 Status reads 0 three times, then 1 -> exactly 4 reads of 0x28, then one read of 0x30.
REQ-038 HRESP=1 on the WR_DIN data phase -> no transfer to 0x20; rsp_valid with rsp_error=1.
REQ-039 POLL_MAX=4 and done never set -> 4 status reads, then rsp_valid with rsp_error=1.
REQ-040 HRESET asserted during RD_STAT -> next cycle HTRANS=IDLE, cmd_ready=1, and rsp_valid is never asserted.
